stream_mux2: RTL and testbench

STREAM_MUX2 -- requirements
Module: stream_mux2

---
 rtl/stream_mux2.sv | 139 +++++++++++++
 tb/tb_stream_mux2.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux2.sv
// stream_mux2: two-input packet-aware stream merger.
// Channels B and C are arbitrated round-robin at packet boundaries. Once a
// channel wins the first beat of a multi-beat packet, it keeps the output
// until its last beat is accepted. Merged beats land in a single output
// register that can drain and reload in the same cycle.
//
// Handshake rule (all three streams): a beat moves on a rising clk edge when
// valid and ready are both high. valid never depends on ready. inB_ready and
// inC_ready are combinational from state, pointer, both valids and the output
// register's ability to load, and are never high together.
module stream_mux2 #(
  parameter int WIDTH = 2,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inB,
  input  logic             inB_valid,
  input  logic             inB_last,
  output logic             inB_ready,
  input  logic [WIDTH-1:0] inC,
  input  logic             inC_valid,
  input  logic             inC_last,
  output logic             inC_ready,
  output logic [WIDTH-1:0] outA,
  output logic             outA_valid,
  output logic             outA_last,
  output logic             outA_sel,
  input  logic             outA_ready,
  output logic [CNTW-1:0]  cntB,
  output logic [CNTW-1:0]  cntC,
  output logic [1:0]       dbg_state,
  output logic             dbg_ptr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_B = 2'd1,
    LOCK_C = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   ptr_q, ptr_d;
  logic   can_load;
  logic   xfer_b, xfer_c;

  // The output register can take a beat when empty or being drained now.
  assign can_load = !outA_valid || outA_ready;

  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

  // State and round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Grant logic, transfer detection and next state / pointer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    inB_ready = 1'b0;
    inC_ready = 1'b0;
    xfer_b    = 1'b0;
    xfer_c    = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          // Preferred channel wins a tie; a lone requester always wins.
          inB_ready = can_load && inB_valid && (!ptr_q || !inC_valid);
          inC_ready = can_load && inC_valid && (ptr_q || !inB_valid);
        end
        LOCK_B: inB_ready = can_load;
        LOCK_C: inC_ready = can_load;
        default: begin
          inB_ready = 1'b0;
          inC_ready = 1'b0;
        end
      endcase
    end
    xfer_b = inB_valid && inB_ready;
    xfer_c = inC_valid && inC_ready;
    if (xfer_b) begin
      if (inB_last) begin
        state_d = IDLE;
        ptr_d   = 1'b1;
      end else begin
        state_d = LOCK_B;
      end
    end else if (xfer_c) begin
      if (inC_last) begin
        state_d = IDLE;
        ptr_d   = 1'b0;
      end else begin
        state_d = LOCK_C;
      end
    end
  end

  // One-entry output register: load on a transfer, else drain when accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outA       <= '0;
      outA_valid <= 1'b0;
      outA_last  <= 1'b0;
      outA_sel   <= 1'b0;
    end else if (xfer_b) begin
      outA       <= inB;
      outA_valid <= 1'b1;
      outA_last  <= inB_last;
      outA_sel   <= 1'b0;
    end else if (xfer_c) begin
      outA       <= inC;
      outA_valid <= 1'b1;
      outA_last  <= inC_last;
      outA_sel   <= 1'b1;
    end else if (outA_ready) begin
      outA_valid <= 1'b0;
    end
  end

  // Per-channel accepted-beat counters, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntB <= '0;
      cntC <= '0;
    end else begin
      if (xfer_b) cntB <= cntB + CNTW'(1);
      if (xfer_c) cntC <= cntC + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_stream_mux2.sv
// tb_stream_mux2: directed bench for stream_mux2 with a packet-level
// reference model checked every cycle and a scoreboard of hand-written
// expected output beats.
module tb_stream_mux2;

  localparam int WIDTH = 2;
  localparam int CNTW  = 8;
  localparam int ST_IDLE   = 0;
  localparam int ST_LOCK_B = 1;
  localparam int ST_LOCK_C = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] inB, inC;
  logic inB_valid, inB_last, inC_valid, inC_last, outA_ready;
  logic inB_ready, inC_ready;
  logic [WIDTH-1:0] outA;
  logic outA_valid, outA_last, outA_sel;
  logic [CNTW-1:0] cntB, cntC;
  logic [1:0] dbg_state;
  logic dbg_ptr;

  stream_mux2 #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .inB(inB), .inB_valid(inB_valid), .inB_last(inB_last), .inB_ready(inB_ready),
    .inC(inC), .inC_valid(inC_valid), .inC_last(inC_last), .inC_ready(inC_ready),
    .outA(outA), .outA_valid(outA_valid), .outA_last(outA_last), .outA_sel(outA_sel),
    .outA_ready(outA_ready), .cntB(cntB), .cntC(cntC),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // owner: 0 = no packet open, 1 = B mid-packet, 2 = C mid-packet.
  int               m_owner;
  int               m_pref;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             m_sel;
  int               m_cntb, m_cntc;
  logic             m_gb, m_gc;

  // Who may hand over a beat this cycle.
  always_comb begin
    m_gb = 1'b0;
    m_gc = 1'b0;
    if (rst_n && (!m_valid || outA_ready)) begin
      if (m_owner == 1) m_gb = 1'b1;
      else if (m_owner == 2) m_gc = 1'b1;
      else if (inB_valid && (m_pref == 0 || !inC_valid)) m_gb = 1'b1;
      else if (inC_valid && (m_pref == 1 || !inB_valid)) m_gc = 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= 0; m_pref <= 0; m_valid <= 1'b0; m_data <= '0;
      m_last <= 1'b0; m_sel <= 1'b0; m_cntb <= 0; m_cntc <= 0;
    end else if (m_gb && inB_valid) begin
      m_valid <= 1'b1; m_data <= inB; m_last <= inB_last; m_sel <= 1'b0;
      m_cntb  <= (m_cntb + 1) % (1 << CNTW);
      m_owner <= inB_last ? 0 : 1;
      if (inB_last) m_pref <= 1;
    end else if (m_gc && inC_valid) begin
      m_valid <= 1'b1; m_data <= inC; m_last <= inC_last; m_sel <= 1'b1;
      m_cntc  <= (m_cntc + 1) % (1 << CNTW);
      m_owner <= inC_last ? 0 : 2;
      if (inC_last) m_pref <= 0;
    end else if (outA_ready) begin
      m_valid <= 1'b0;
    end
  end

  // ---------------- scoreboard + per-cycle compare ----------------
  logic [WIDTH+1:0] exp_q[$];

  always @(negedge clk) begin
    logic [WIDTH+1:0] e;
    check("inB_ready", 32'(inB_ready), 32'(m_gb));
    check("inC_ready", 32'(inC_ready), 32'(m_gc));
    check("outA_valid", 32'(outA_valid), 32'(m_valid));
    if (m_valid || !rst_n) begin
      check("outA", 32'(outA), 32'(m_data));
      check("outA_last", 32'(outA_last), 32'(m_last));
      check("outA_sel", 32'(outA_sel), 32'(m_sel));
    end
    check("cntB", 32'(cntB), 32'(m_cntb));
    check("cntC", 32'(cntC), 32'(m_cntc));
    if (rst_n && outA_valid && outA_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'({outA_sel, outA_last, outA}), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_beat", 32'({outA_sel, outA_last, outA}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic sel, input logic last, input logic [WIDTH-1:0] d);
    exp_q.push_back({sel, last, d});
  endtask

  task automatic check_reset_outputs();
    check("rst_outA_valid", 32'(outA_valid), 0);
    check("rst_outA", 32'(outA), 0);
    check("rst_inB_ready", 32'(inB_ready), 0);
    check("rst_inC_ready", 32'(inC_ready), 0);
    check("rst_cntB", 32'(cntB), 0);
    check("rst_cntC", 32'(cntC), 0);
    check("rst_state", 32'(dbg_state), ST_IDLE);
    check("rst_ptr", 32'(dbg_ptr), 0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    inB = '0; inC = '0; inB_valid = 0; inB_last = 0;
    inC_valid = 0; inC_last = 0; outA_ready = 1;
    inB_valid = 1; inC_valid = 1;   // valid during reset must be ignored
    repeat (3) step();
    check_reset_outputs();
    inB_valid = 0; inC_valid = 0;
    rst_n = 1;
    step();

    // Single-beat packets from both sides alternate B,C,B,C.
    push_beat(0, 1, 2'b10); push_beat(1, 1, 2'b01);
    push_beat(0, 1, 2'b10); push_beat(1, 1, 2'b01);
    inB = 2'b10; inB_last = 1; inB_valid = 1;
    inC = 2'b01; inC_last = 1; inC_valid = 1;
    step();
    check("alt_first_valid", 32'(outA_valid), 1);
    check("alt_first_sel", 32'(outA_sel), 0);
    repeat (3) step();
    inB_valid = 0; inC_valid = 0;
    step(); step();
    check("alt_cntB", 32'(cntB), 2);
    check("alt_cntC", 32'(cntC), 2);

    // 3-beat B packet must not be interrupted by a waiting C.
    push_beat(0, 0, 2'b01); push_beat(0, 0, 2'b10);
    push_beat(0, 1, 2'b11); push_beat(1, 1, 2'b00);
    inB = 2'b01; inB_last = 0; inB_valid = 1;
    inC = 2'b00; inC_last = 1; inC_valid = 1;
    #1 check("pkt_c_wait0", 32'(inC_ready), 0);
    step();
    inB = 2'b10;
    #1 check("pkt_c_wait1", 32'(inC_ready), 0);
    step();
    inB = 2'b11; inB_last = 1;
    #1 check("pkt_c_wait2", 32'(inC_ready), 0);
    step();
    inB_valid = 0;
    step();
    inC_valid = 0;
    step(); step();

    // Back-pressure: held beat stays put for 4 cycles, then drain+load together.
    push_beat(0, 1, 2'b11); push_beat(0, 1, 2'b10);
    outA_ready = 0;
    inB = 2'b11; inB_last = 1; inB_valid = 1;
    step();
    inB = 2'b10;
    for (int k = 0; k < 4; k++) begin
      check("hold_inB_ready", 32'(inB_ready), 0);
      check("hold_inC_ready", 32'(inC_ready), 0);
      check("hold_outA", 32'(outA), 2'b11);
      check("hold_cntB", 32'(cntB), 6);
      step();
    end
    outA_ready = 1;
    #1 check("release_inB_ready", 32'(inB_ready), 1);
    step();
    inB_valid = 0;
    check("reload_outA", 32'(outA), 2'b10);
    check("reload_valid", 32'(outA_valid), 1);
    step(); step();

    // C locked; C stalls two cycles while B waits.
    push_beat(1, 0, 2'b01); push_beat(1, 1, 2'b11); push_beat(0, 1, 2'b10);
    inC = 2'b01; inC_last = 0; inC_valid = 1;
    inB = 2'b10; inB_last = 1; inB_valid = 1;
    step();
    inC_valid = 0;
    #1 check("lockc_b_wait0", 32'(inB_ready), 0);
    check("lockc_state", 32'(dbg_state), ST_LOCK_C);
    step();
    check("lockc_b_wait1", 32'(inB_ready), 0);
    step();
    inC = 2'b11; inC_last = 1; inC_valid = 1;
    #1 check("lockc_resume", 32'(inC_ready), 1);
    step();
    inC_valid = 0;
    #1 check("lockc_idle", 32'(dbg_state), ST_IDLE);
    check("lockc_b_grant", 32'(inB_ready), 1);
    step();
    inB_valid = 0;
    step(); step();
    check("lockc_cntB", 32'(cntB), 8);
    check("lockc_cntC", 32'(cntC), 5);

    // Counter wrap: 256 single-beat B packets from a fresh reset.
    rst_n = 0;
    #1 check_reset_outputs();
    step(); step();
    rst_n = 1;
    inB_valid = 1; inB_last = 1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      inB = iv[1:0];
      push_beat(0, 1, iv[1:0]);
      if (i == 255) check("wrap_cntB_255", 32'(cntB), 255);
      step();
    end
    inB_valid = 0;
    check("wrap_cntB_0", 32'(cntB), 0);
    check("wrap_cntC_0", 32'(cntC), 0);
    step(); step();

    // Reset in the middle of a C packet drops the lock and held beat.
    inC = 2'b10; inC_last = 0; inC_valid = 1;
    step();
    inC = 2'b01; inC_last = 1;
    #2 rst_n = 0;
    #1 check("midrst_outA_valid", 32'(outA_valid), 0);
    check("midrst_inC_ready", 32'(inC_ready), 0);
    check("midrst_state", 32'(dbg_state), ST_IDLE);
    check("midrst_cntC", 32'(cntC), 0);
    @(posedge clk); #1;
    push_beat(0, 0, 2'b11); push_beat(0, 1, 2'b00);
    rst_n = 1;
    inC_valid = 0;
    inB = 2'b11; inB_last = 0; inB_valid = 1;
    #1 check("postrst_b_grant", 32'(inB_ready), 1);
    step();
    check("postrst_outA", 32'(outA), 2'b11);
    check("postrst_sel", 32'(outA_sel), 0);
    check("postrst_state", 32'(dbg_state), ST_LOCK_B);
    inB = 2'b00; inB_last = 1;
    step();
    inB_valid = 0;
    step(); step();
    check("postrst_cntB", 32'(cntB), 2);

    // ---------------- final report ----------------
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
